// File: rtl/se_vga_pkg.sv
// Shared SE-VGA constants: 640x480@60 raster timing, the centred 512x342 SE
// window, the character-slot sequence constants and the buffer-select type.
package se_vga_pkg;

  // Horizontal timing in pixel clocks
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  // Vertical timing in lines
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // SE image placement inside the visible raster
  localparam int WIN_H0    = 64;
  localparam int WIN_V0    = 69;
  localparam int WIN_W     = 512;
  localparam int WIN_LINES = 342;

  // Counter and address widths
  localparam int CNT_W  = 10;
  localparam int ADDR_W = 15;

  // VRAM reads own slot 0 of every 8-pixel character; the CPU snoop write
  // engine schedules its writes in the other seven slots.
  localparam logic [2:0] FETCH_SEQ = 3'd0;
  // The shift register reloads on the last pixel of a character
  localparam logic [2:0] LOAD_SEQ  = 3'd7;

  typedef enum logic {
    BUF_ALT  = 1'b0,
    BUF_MAIN = 1'b1
  } buf_sel_t;

  // Inclusive range test on counter values
  function automatic logic in_range(input logic [CNT_W-1:0] val,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vram_scanout_if.sv
// VRAM read-port bundle between the scanout engine (master) and the
// frame-buffer memory / bus mux (slave).
interface vram_scanout_if;
  import se_vga_pkg::*;

  logic [7:0]        vramDataIn;
  logic [ADDR_W-1:0] vramAddr;
  logic              nvramOE;
  logic              nvramCE0;
  logic              nvramCE1;
  logic              rdSlot;

  modport master (
    input  vramDataIn,
    output vramAddr,
    output nvramOE,
    output nvramCE0,
    output nvramCE1,
    output rdSlot
  );

  modport slave (
    output vramDataIn,
    input  vramAddr,
    input  nvramOE,
    input  nvramCE0,
    input  nvramCE1,
    input  rdSlot
  );

endinterface

// File: rtl/vga_timing.sv
// VGA raster counters, registered syncs and the per-pixel strobes that steer
// the VRAM fetch, shift-register load and active-display region.
module vga_timing #(
  parameter int H_VIS     = se_vga_pkg::H_VIS,
  parameter int H_FP      = se_vga_pkg::H_FP,
  parameter int H_SYNC    = se_vga_pkg::H_SYNC,
  parameter int H_BP      = se_vga_pkg::H_BP,
  parameter int V_VIS     = se_vga_pkg::V_VIS,
  parameter int V_FP      = se_vga_pkg::V_FP,
  parameter int V_SYNC    = se_vga_pkg::V_SYNC,
  parameter int V_BP      = se_vga_pkg::V_BP,
  parameter int WIN_H0    = se_vga_pkg::WIN_H0,
  parameter int WIN_V0    = se_vga_pkg::WIN_V0,
  parameter int WIN_W     = se_vga_pkg::WIN_W,
  parameter int WIN_LINES = se_vga_pkg::WIN_LINES
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] seq,
  output logic       nh_sync,
  output logic       nv_sync,
  output logic       fetch,
  output logic       load,
  output logic       disp,
  output logic       frame_start,
  output logic       buf_latch
);
  import se_vga_pkg::*;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_BLANK  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] WV_FIRST = CNT_W'(WIN_V0);
  localparam logic [CNT_W-1:0] WV_LAST  = CNT_W'(WIN_V0 + WIN_LINES - 1);
  // A byte is fetched one character ahead of where it is shown, so the fetch
  // run starts 8 pixels before the window and stops one character early.
  localparam logic [CNT_W-1:0] F_FIRST  = CNT_W'(WIN_H0 - 8);
  localparam logic [CNT_W-1:0] F_LAST   = CNT_W'(WIN_H0 + WIN_W - 16);
  localparam logic [CNT_W-1:0] L_FIRST  = CNT_W'(WIN_H0 - 1);
  localparam logic [CNT_W-1:0] L_LAST   = CNT_W'(WIN_H0 + WIN_W - 9);
  localparam logic [CNT_W-1:0] D_FIRST  = CNT_W'(WIN_H0);
  localparam logic [CNT_W-1:0] D_LAST   = CNT_W'(WIN_H0 + WIN_W - 1);

  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             win_line;

  assign seq = h_count[2:0];

  // Pixel and line counters; the line counter advances on each pixel wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + ONE;
    end else begin
      h_count <= h_count + ONE;
    end
  end

  // Registered syncs, so each edge trails its count match by one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nh_sync <= 1'b1;
      nv_sync <= 1'b1;
    end else begin
      nh_sync <= !in_range(h_count, HS_FIRST, HS_LAST);
      nv_sync <= !in_range(v_count, VS_FIRST, VS_LAST);
    end
  end

  // Decode window, fetch, load, display and frame-event strobes from the counts
  always_comb begin
    win_line    = in_range(v_count, WV_FIRST, WV_LAST);
    fetch       = win_line && (seq == FETCH_SEQ) && in_range(h_count, F_FIRST, F_LAST);
    load        = win_line && (seq == LOAD_SEQ) && in_range(h_count, L_FIRST, L_LAST);
    disp        = win_line && in_range(h_count, D_FIRST, D_LAST);
    frame_start = (h_count == '0) && (v_count == '0);
    buf_latch   = (h_count == '0) && (v_count == V_BLANK);
  end

endmodule

// File: rtl/vram_scanout.sv
// Read side of the SE-VGA frame-buffer copy: fetches one VRAM byte per
// character slot and shifts it out as 1-bit video centred in the VGA raster.
module vram_scanout #(
  parameter int H_VIS     = se_vga_pkg::H_VIS,
  parameter int H_FP      = se_vga_pkg::H_FP,
  parameter int H_SYNC    = se_vga_pkg::H_SYNC,
  parameter int H_BP      = se_vga_pkg::H_BP,
  parameter int V_VIS     = se_vga_pkg::V_VIS,
  parameter int V_FP      = se_vga_pkg::V_FP,
  parameter int V_SYNC    = se_vga_pkg::V_SYNC,
  parameter int V_BP      = se_vga_pkg::V_BP,
  parameter int WIN_H0    = se_vga_pkg::WIN_H0,
  parameter int WIN_V0    = se_vga_pkg::WIN_V0,
  parameter int WIN_W     = se_vga_pkg::WIN_W,
  parameter int WIN_LINES = se_vga_pkg::WIN_LINES
) (
  input  logic                  pixClock,
  input  logic                  nReset,
  input  logic                  vidBufSel,
  vram_scanout_if.master        vram,
  output logic [2:0]            seq,
  output logic                  nhSync,
  output logic                  nvSync,
  output logic                  vidOut
);
  import se_vga_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic              fetch;
  logic              load;
  logic              disp;
  logic              frame_start;
  logic              buf_latch;
  logic [ADDR_W-1:0] fetch_addr;
  logic [7:0]        hold_reg;
  logic [7:0]        shift_reg;
  buf_sel_t          buf_sel;

  vga_timing #(
    .H_VIS     (H_VIS),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VIS     (V_VIS),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP),
    .WIN_H0    (WIN_H0),
    .WIN_V0    (WIN_V0),
    .WIN_W     (WIN_W),
    .WIN_LINES (WIN_LINES)
  ) u_timing (
    .clk         (pixClock),
    .rst_n       (nReset),
    .seq         (seq),
    .nh_sync     (nhSync),
    .nv_sync     (nvSync),
    .fetch       (fetch),
    .load        (load),
    .disp        (disp),
    .frame_start (frame_start),
    .buf_latch   (buf_latch)
  );

  // Read address restarts each frame and steps once per completed fetch;
  // it may run past the window end harmlessly since no further fetches occur
  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      fetch_addr <= '0;
    end else if (frame_start) begin
      fetch_addr <= '0;
    end else if (fetch) begin
      fetch_addr <= fetch_addr + ADDR_ONE;
    end
  end

  // Capture the read byte on the edge that closes the fetch slot
  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      hold_reg <= '0;
    end else if (fetch) begin
      hold_reg <= vram.vramDataIn;
    end
  end

  // Reload on the last pixel of a character, otherwise shift out MSB-first
  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= hold_reg;
    end else begin
      shift_reg <= {shift_reg[6:0], 1'b0};
    end
  end

  // Buffer choice changes only at the start of vertical blanking to avoid tearing
  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      buf_sel <= BUF_MAIN;
    end else if (buf_latch) begin
      buf_sel <= buf_sel_t'(vidBufSel);
    end
  end

  // VRAM control: the bus is claimed only during the fetch slot
  always_comb begin
    vram.vramAddr = fetch_addr;
    vram.rdSlot   = 1'b0;
    vram.nvramOE  = 1'b1;
    vram.nvramCE0 = 1'b1;
    vram.nvramCE1 = 1'b1;
    if (fetch) begin
      vram.rdSlot  = 1'b1;
      vram.nvramOE = 1'b0;
      if (buf_sel == BUF_MAIN) begin
        vram.nvramCE0 = 1'b0;
      end else begin
        vram.nvramCE1 = 1'b0;
      end
    end
  end

  // Mac pixels are 1 = black, so invert inside the window and blank elsewhere
  always_comb begin
    vidOut = 1'b0;
    if (disp) begin
      vidOut = ~shift_reg[7];
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// Directed bench for vram_scanout on a reduced raster (80x27 clocks/lines,
// 32x6 window at 16,4) so that several full frames fit in a short run.
module tb_vram_scanout;

  localparam int HT    = 80;
  localparam int VT    = 27;
  localparam int FRAME = HT * VT;

  logic       pixClock = 1'b0;
  logic       nReset   = 1'b0;
  logic       vidBufSel = 1'b1;
  logic [2:0] seq;
  logic       nhSync;
  logic       nvSync;
  logic       vidOut;

  logic [7:0] mem [0:31];
  logic       vid_log [0:2*FRAME-1];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  vram_scanout_if vram();

  vram_scanout #(
    .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .WIN_H0(16), .WIN_V0(4), .WIN_W(32), .WIN_LINES(6)
  ) dut (
    .pixClock  (pixClock),
    .nReset    (nReset),
    .vidBufSel (vidBufSel),
    .vram      (vram.master),
    .seq       (seq),
    .nhSync    (nhSync),
    .nvSync    (nvSync),
    .vidOut    (vidOut)
  );

  always #5 pixClock = ~pixClock;

  // VRAM model: drives data only while read-enabled on one of the chips
  always_comb begin
    vram.vramDataIn = 8'h00;
    if (!vram.nvramOE && (!vram.nvramCE0 || !vram.nvramCE1))
      vram.vramDataIn = mem[vram.vramAddr[4:0]];
  end

  task automatic tick();
    @(posedge pixClock);
    @(negedge pixClock);
    cyc++;
  endtask

  task automatic test_reset();
    @(negedge pixClock);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({nhSync, nvSync, vidOut, vram.nvramOE, vram.nvramCE0, vram.nvramCE1, vram.rdSlot} !== 7'b1101110) begin
        bad++;
        $display("[TB] FAIL reset_ctrl: got %b expected 1101110", {nhSync, nvSync, vidOut, vram.nvramOE, vram.nvramCE0, vram.nvramCE1, vram.rdSlot});
      end
      total++;
      if (vram.vramAddr !== 15'd0 || seq !== 3'd0) begin
        bad++;
        $display("[TB] FAIL reset_addr_seq: got addr=%0d seq=%0d expected 0 0", vram.vramAddr, seq);
      end
      tick();
    end
    nReset = 1'b1;
    cyc = 0;
  endtask

  // Two full frames: sync timing, seq, fetch slots/addresses and video model
  task automatic test_frames();
    int h, v, f;
    int hs_first = -1, hs_second = -1, hs_rise = -1, hs_falls = 0;
    int vs_first = -1, vs_second = -1, vs_rise = -1;
    int seq_errs = 0, vid_errs = 0, fetch_errs = 0, fexp = 0;
    int first_fetch = -1, first_addr = -1, last_addr = -1;
    int rd_cnt [2];
    logic prev_hs = 1'b1, prev_vs = 1'b1, exp_vid, is_slot;
    logic [7:0] b;
    rd_cnt[0] = 0;
    rd_cnt[1] = 0;
    for (int i = 0; i < 2*FRAME; i++) begin
      h = cyc % HT;
      v = (cyc / HT) % VT;
      f = cyc / FRAME;
      if (seq !== 3'(h)) seq_errs++;
      if (prev_hs && !nhSync) begin
        if (hs_first < 0) hs_first = cyc;
        else if (hs_second < 0) hs_second = cyc;
        hs_falls++;
      end
      if (!prev_hs && nhSync && hs_rise < 0) hs_rise = cyc;
      if (prev_vs && !nvSync) begin
        if (vs_first < 0) vs_first = cyc;
        else if (vs_second < 0) vs_second = cyc;
      end
      if (!prev_vs && nvSync && vs_rise < 0) vs_rise = cyc;
      prev_hs = nhSync;
      prev_vs = nvSync;
      exp_vid = 1'b0;
      if (v >= 4 && v <= 9 && h >= 16 && h <= 47) begin
        b = mem[(v-4)*4 + (h-16)/8];
        exp_vid = ~b[7 - ((h-16) % 8)];
      end
      vid_log[cyc] = vidOut;
      if (vidOut !== exp_vid) vid_errs++;
      if (h == 0 && v == 0) fexp = 0;
      is_slot = (v >= 4 && v <= 9 && (h % 8) == 0 && h >= 8 && h <= 32);
      if (vram.rdSlot !== is_slot) fetch_errs++;
      if (vram.rdSlot === 1'b1) begin
        rd_cnt[f]++;
        if (first_fetch < 0) begin
          first_fetch = cyc;
          first_addr = int'(vram.vramAddr);
        end
        if (f == 0) last_addr = int'(vram.vramAddr);
        if (seq !== 3'd0 || vram.nvramOE !== 1'b0 || vram.nvramCE0 !== 1'b0 ||
            vram.nvramCE1 !== 1'b1 || vram.vramAddr !== 15'(fexp)) fetch_errs++;
        fexp++;
      end else if (vram.nvramOE !== 1'b1 || vram.nvramCE0 !== 1'b1 || vram.nvramCE1 !== 1'b1) begin
        fetch_errs++;
      end
      tick();
    end
    total++; if (seq_errs !== 0)  begin bad++; $display("[TB] FAIL seq_track: got %0d bad cycles expected 0", seq_errs); end
    total++; if (hs_first !== 69) begin bad++; $display("[TB] FAIL hs_first_fall: got %0d expected 69", hs_first); end
    total++; if (hs_second - hs_first !== 80) begin bad++; $display("[TB] FAIL hs_period: got %0d expected 80", hs_second - hs_first); end
    total++; if (hs_rise - hs_first !== 8) begin bad++; $display("[TB] FAIL hs_width: got %0d expected 8", hs_rise - hs_first); end
    total++; if (hs_falls !== 54) begin bad++; $display("[TB] FAIL hs_count: got %0d expected 54", hs_falls); end
    total++; if (vs_first !== 1761) begin bad++; $display("[TB] FAIL vs_first_fall: got %0d expected 1761", vs_first); end
    total++; if (vs_second - vs_first !== 2160) begin bad++; $display("[TB] FAIL vs_period: got %0d expected 2160", vs_second - vs_first); end
    total++; if (vs_rise - vs_first !== 160) begin bad++; $display("[TB] FAIL vs_width: got %0d expected 160", vs_rise - vs_first); end
    total++; if (vid_errs !== 0) begin bad++; $display("[TB] FAIL video_model: got %0d bad pixels expected 0", vid_errs); end
    total++; if (fetch_errs !== 0) begin bad++; $display("[TB] FAIL fetch_slots: got %0d bad cycles expected 0", fetch_errs); end
    total++; if (first_fetch !== 328) begin bad++; $display("[TB] FAIL first_fetch_cycle: got %0d expected 328", first_fetch); end
    total++; if (first_addr !== 0) begin bad++; $display("[TB] FAIL first_fetch_addr: got %0d expected 0", first_addr); end
    total++; if (last_addr !== 23) begin bad++; $display("[TB] FAIL last_fetch_addr: got %0d expected 23", last_addr); end
    total++; if (rd_cnt[0] !== 24) begin bad++; $display("[TB] FAIL rd_count_f0: got %0d expected 24", rd_cnt[0]); end
    total++; if (rd_cnt[1] !== 24) begin bad++; $display("[TB] FAIL rd_count_f1: got %0d expected 24", rd_cnt[1]); end
  endtask

  // Byte 0x80 at address 0: one black pixel then white, on line 4 from h=16
  task automatic test_latency();
    total++; if (vid_log[335] !== 1'b0) begin bad++; $display("[TB] FAIL lat_h15: got %b expected 0", vid_log[335]); end
    total++; if (vid_log[336] !== 1'b0) begin bad++; $display("[TB] FAIL lat_h16: got %b expected 0", vid_log[336]); end
    total++; if (vid_log[337] !== 1'b1) begin bad++; $display("[TB] FAIL lat_h17: got %b expected 1", vid_log[337]); end
    total++; if (vid_log[343] !== 1'b1) begin bad++; $display("[TB] FAIL lat_h23: got %b expected 1", vid_log[343]); end
    total++; if (vid_log[344] !== 1'b1) begin bad++; $display("[TB] FAIL lat_h24: got %b expected 1", vid_log[344]); end
    total++; if (vid_log[368] !== 1'b0) begin bad++; $display("[TB] FAIL lat_h48: got %b expected 0", vid_log[368]); end
  endtask

  // Switch to Alt mid-window: current frame stays on Main, next frame uses Alt
  task automatic test_buf_switch();
    int base, l, fr;
    int ce0_cnt [2];
    int ce1_cnt [2];
    int f3_addr = -1;
    base = cyc;
    ce0_cnt[0] = 0; ce0_cnt[1] = 0; ce1_cnt[0] = 0; ce1_cnt[1] = 0;
    for (int i = 0; i < 2*FRAME; i++) begin
      l = cyc - base;
      fr = l / FRAME;
      if (l == 6*HT) vidBufSel = 1'b0;
      if (vram.rdSlot === 1'b1) begin
        if (vram.nvramCE0 === 1'b0) ce0_cnt[fr]++;
        if (vram.nvramCE1 === 1'b0) ce1_cnt[fr]++;
        if (fr == 1 && f3_addr < 0) f3_addr = int'(vram.vramAddr);
      end
      tick();
    end
    total++; if (ce0_cnt[0] !== 24) begin bad++; $display("[TB] FAIL sw_f2_ce0: got %0d expected 24", ce0_cnt[0]); end
    total++; if (ce1_cnt[0] !== 0)  begin bad++; $display("[TB] FAIL sw_f2_ce1: got %0d expected 0", ce1_cnt[0]); end
    total++; if (ce0_cnt[1] !== 0)  begin bad++; $display("[TB] FAIL sw_f3_ce0: got %0d expected 0", ce0_cnt[1]); end
    total++; if (ce1_cnt[1] !== 24) begin bad++; $display("[TB] FAIL sw_f3_ce1: got %0d expected 24", ce1_cnt[1]); end
    total++; if (f3_addr !== 0) begin bad++; $display("[TB] FAIL sw_f3_first_addr: got %0d expected 0", f3_addr); end
  endtask

  // Reset during a fetch slot on line 7, then check the restart from 0,0
  task automatic test_reset_mid();
    int ff = -1, ff_addr = -1;
    logic ff_ce0 = 1'b1;
    for (int i = 0; i < FRAME && (cyc % FRAME) != (7*HT + 24); i++) tick();
    total++;
    if (vram.rdSlot !== 1'b1 || vram.vramAddr !== 15'd14 || vram.nvramCE1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL pre_reset_fetch: got rd=%b addr=%0d ce1=%b expected 1 14 0", vram.rdSlot, vram.vramAddr, vram.nvramCE1);
    end
    nReset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({nhSync, nvSync, vidOut, vram.nvramOE, vram.nvramCE0, vram.nvramCE1, vram.rdSlot} !== 7'b1101110 ||
          vram.vramAddr !== 15'd0 || seq !== 3'd0) begin
        bad++;
        $display("[TB] FAIL mid_reset_outputs: got %b addr=%0d seq=%0d expected 1101110 0 0",
                 {nhSync, nvSync, vidOut, vram.nvramOE, vram.nvramCE0, vram.nvramCE1, vram.rdSlot}, vram.vramAddr, seq);
      end
      if (i < 3) tick();
    end
    @(negedge pixClock);
    nReset = 1'b1;
    cyc = 0;
    total++; if (seq !== 3'd0) begin bad++; $display("[TB] FAIL post_reset_seq: got %0d expected 0", seq); end
    for (int i = 0; i < 400; i++) begin
      if (vram.rdSlot === 1'b1 && ff < 0) begin
        ff = cyc;
        ff_addr = int'(vram.vramAddr);
        ff_ce0 = vram.nvramCE0;
      end
      tick();
    end
    total++; if (ff !== 328) begin bad++; $display("[TB] FAIL post_reset_first_fetch: got %0d expected 328", ff); end
    total++; if (ff_addr !== 0) begin bad++; $display("[TB] FAIL post_reset_addr: got %0d expected 0", ff_addr); end
    total++; if (ff_ce0 !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_main_sel: got %b expected 0", ff_ce0); end
  endtask

  initial begin
    mem[0] = 8'h80;
    for (int i = 1; i < 32; i++) mem[i] = 8'((i * 37 + 90) & 255);
    test_reset();
    test_frames();
    test_latency();
    test_buf_switch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_scanout.md
Name: vram_scanout

Overview:
- Read side of the SE-VGA frame-buffer copy. Generates 640x480@60 VGA timing from the 25.175 MHz pixel clock.
- Fetches one VRAM byte per 8-pixel character slot and serialises it to a 1-bit video output, with the 512x342 SE image centred in the VGA raster.
- Publishes the sequence count that the CPU snoop write engine uses to schedule its VRAM writes. VRAM reads occupy only the seq==0 slot; snoop writes never use that slot.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- WIN_H0, 64, first displayed SE pixel column
- WIN_V0, 69, first displayed SE line
- WIN_W, 512, SE window width in pixels
- WIN_LINES, 342, SE window height in lines

Ports:
- pixClock  in  1  25.175 MHz pixel clock; all state on rising edge
- nReset  in  1  asynchronous active-low reset
- vramDataIn  in  8  VRAM read data
- vidBufSel  in  1  requested display buffer; 1 = Main, 0 = Alt
- seq  out  3  hCount[2:0]
- vramAddr  out  15  VRAM read byte address
- nvramOE  out  1  VRAM output enable, active low
- nvramCE0  out  1  Main buffer chip enable, active low
- nvramCE1  out  1  Alt buffer chip enable, active low
- rdSlot  out  1  high while this block owns the VRAM bus (address/data mux select)
- nhSync  out  1  horizontal sync, active low
- nvSync  out  1  vertical sync, active low
- vidOut  out  1  pixel; 1 = white, 0 = black

Behaviour:
- Reset values: hCount=0, vCount=0, fetchAddr=0, shift register=0, holding register=0, latched buffer select=1 (Main). Outputs: nhSync=1, nvSync=1, vidOut=0, nvramOE=1, nvramCE0=1, nvramCE1=1, rdSlot=0, vramAddr=0.
- Counters: hCount 0..799 wraps to 0 and increments vCount. vCount 0..524 wraps to 0.
- Sync: nhSync=0 for hCount 656..751. nvSync=0 for vCount 490..491. Both are registered, so their edges appear one clock after the count match.
- Window: the line is in the window when WIN_V0 <= vCount < WIN_V0+WIN_LINES (69..410).
- Fetch condition: on a window line, at hCount=8m with m in 7..70 (hCount 56..560, seq==0).
  - Drive rdSlot=1, nvramOE=0, vramAddr=fetchAddr, and assert the chip enable of the latched buffer: CE0 for Main, CE1 for Alt.
  - Capture vramDataIn into the holding register on the rising edge that ends the slot.
  - Increment fetchAddr by 1 (15-bit, no saturation).
- At all other times: rdSlot=0, nvramOE=1, both chip enables =1, vramAddr=fetchAddr.
- Shift register:
  - At hCount=8m+7 with m in 7..70 on a window line, load the holding register into the shift register.
  - Otherwise shift left one bit each clock, filling with 0.
- Display: while hCount is in 64..575 on a window line, vidOut = NOT shiftReg[7] (Mac 1 = black). Outside the window vidOut=0.
- Latency: the byte fetched at 8m is displayed MSB-first over hCount 8(m+1)..8(m+1)+7.
- Address range: 64 fetches per line × 342 lines = 21888 bytes, so fetchAddr spans 0x0000..0x557F.
  - fetchAddr resets to 0 at hCount=0, vCount=0.
  - Reaching 0x5580 before the frame end is legal; no further fetches occur because the line is outside the window.
- Buffer select: sample vidBufSel into the latched select only at hCount=0, vCount=V_VIS (480), the start of vertical blanking. A change mid-frame takes effect on the next frame, which prevents tearing.
- Simultaneous events: a fetch and a shift-register load never coincide on the same clock. Counter wrap and buffer latch may coincide without conflict.
- Reset mid-frame: all state returns to reset values immediately. Counting resumes from 0,0 on the first clock after release.

Decomposition:
- se_vga_pkg holds the shared timing constants (H_*, V_*, WIN_*), the derived totals (H_TOTAL=800, V_TOTAL=525) and the FETCH_SEQ=0 slot constant. The CPU snoop's write-window limits also reference FETCH_SEQ.
- One sub-module, vga_timing: the hCount/vCount counters, registered syncs, seq, and the window/fetch/load strobes.
- vram_scanout owns fetchAddr, the holding and shift registers, buffer-select latching and the VRAM control outputs.

Test Plan:
- Release reset, run 2 frames -> nhSync period 800 clocks with low width 96; nvSync period 420000 clocks with low width 1600 clocks; seq equals hCount[2:0].
- VRAM model returns the address low byte, vidBufSel=1 -> the first fetch is at vCount=69, hCount=56 with vramAddr=0, nvramCE0=0, nvramCE1=1; the last fetch of the frame has vramAddr=0x557F; no fetch outside vCount 69..410.
- Byte 0x80 at address 0 -> vidOut=0 at hCount 64 and 1 at hCount 65..71 on line 69; vidOut=0 at hCount 63 and 576.
- Count rdSlot pulses -> exactly 21888 per frame, each with seq==0 and nvramOE=0.
- Toggle vidBufSel to 0 at vCount=200 -> fetches keep nvramCE0=0 until vCount 480; the next frame uses nvramCE1=0.
- Assert nReset at vCount=300, hCount=333 for 3 clocks -> all outputs at reset values during reset; after release hCount=0, vCount=0, and the next frame's first fetch is at address 0.
